// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the 4-state hard-decision Viterbi decoder step.
// Clears the decoder, streams N data pairs plus TAIL termination pairs into it,
// packs the decoded data bits LSB-first into OUT_W-bit words and flags a
// trellis that does not terminate in state 00.
module viterbi_frame_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned TAIL  = 2,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [1:0]       in_sym,
  output logic             in_ready,
  output logic             dec_reset,
  output logic             dec_en,
  output logic [1:0]       dec_y,
  input  logic             dec_x,
  input  logic [1:0]       dec_state,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             done,
  output logic             tail_err
);

  localparam int unsigned CntW = LEN_W + 2;
  localparam int unsigned BitW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    StIdle, StClear, StRun, StTail, StCheck, StDrain, StDone
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [CntW-1:0]  cnt_q;
  logic [BitW-1:0]  bitcnt_q;
  logic [OUT_W-1:0] pack_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_last_q;
  logic             tail_err_q;

  logic             consume;
  logic [CntW-1:0]  cnt_inc;
  logic             last_data;
  logic             last_tail;
  logic [OUT_W-1:0] word;
  logic             word_end;
  logic             load;

  // Handshake, decoder drive and packer next-word decode.
  always_comb begin
    // A held output word blocks intake so a load can never overwrite it.
    in_ready  = ((state_q == StRun) || (state_q == StTail)) && !(out_valid_q && !out_ready);
    consume   = in_valid && in_ready;
    dec_en    = consume;
    dec_y     = in_sym;
    dec_reset = reset || (state_q == StClear);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    tail_err  = tail_err_q;
    cnt_inc   = cnt_q + 1'b1;
    last_data = (cnt_inc == {2'b00, len_q});
    last_tail = (cnt_inc == CntW'(TAIL));
    word      = pack_q | (OUT_W'(dec_x) << bitcnt_q);
    word_end  = (bitcnt_q == BitW'(OUT_W - 1)) || last_data;
    load      = consume && (state_q == StRun) && word_end;
  end

  // Frame FSM, counters, packer and single-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      tail_err_q  <= 1'b0;
    end else begin
      // Load wins over accept so a word can leave and the next arrive on one edge.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= word;
        out_last_q  <= last_data;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_last_q  <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start && (frame_len != '0)) begin
            len_q      <= frame_len;
            tail_err_q <= 1'b0;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            pack_q     <= '0;
            state_q    <= StClear;
          end
        end
        StClear: state_q <= StRun;
        StRun: begin
          if (consume) begin
            if (last_data) begin
              cnt_q   <= '0;
              state_q <= StTail;
            end else begin
              cnt_q <= cnt_inc;
            end
            if (word_end) begin
              pack_q   <= '0;
              bitcnt_q <= '0;
            end else begin
              pack_q   <= word;
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
        end
        StTail: begin
          if (consume) begin
            if (last_tail) begin
              cnt_q   <= '0;
              state_q <= StCheck;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        StCheck: begin
          tail_err_q <= (dec_state != 2'b00);
          state_q    <= StDrain;
        end
        StDrain: if (!out_valid_q) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a behavioural decoder stub.
module tb_viterbi_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] frame_len;
  logic       busy;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       in_ready;
  logic       dec_reset;
  logic       dec_en;
  logic [1:0] dec_y;
  logic       dec_x;
  logic [1:0] dec_state;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       done;
  logic       tail_err;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  logic [7:0] words[$];
  logic       lasts[$];

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.LEN_W(8), .TAIL(2), .OUT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .in_ready  (in_ready),
    .dec_reset (dec_reset),
    .dec_en    (dec_en),
    .dec_y     (dec_y),
    .dec_x     (dec_x),
    .dec_state (dec_state),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .done      (done),
    .tail_err  (tail_err)
  );

  // Decoder stub for the (7,5) code: state = {u[n-2], u[n-1]}, x = y0 ^ u[n-2].
  assign dec_x = dec_y[0] ^ dec_state[1];
  always @(posedge clk) begin
    if (dec_reset) dec_state <= 2'b00;
    else if (dec_en) dec_state <= {dec_state[0], dec_x};
  end

  // Sink: record every accepted word.
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      words.push_back(out_data);
      lasts.push_back(out_last);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] s);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = s;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("push_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Feed cnt symbols from a packed list (symbol i at bits [2i+1:2i]) starting at first.
  task automatic feed(input logic [63:0] syms, input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) push(syms[2*i +: 2]);
  endtask

  task automatic begin_frame(input string tag, input logic [7:0] n);
    words.delete();
    lasts.delete();
    @(negedge clk);
    start     = 1'b1;
    frame_len = n;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_clear"}, dec_reset, 1);
    check({tag, "_errclr"}, tail_err, 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic end_frame(input string tag, input int d0, input int nwords,
                           input logic [7:0] w0, input logic err);
    wait_done();
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_nwords"}, words.size(), nwords);
    if (words.size() >= 1) check({tag, "_w0"}, words[0], w0);
    if (words.size() == nwords) check({tag, "_last"}, lasts[nwords-1], 1);
    if (words.size() > 1) check({tag, "_last0"}, lasts[0], 0);
    check({tag, "_tailerr"}, tail_err, err);
  endtask

  logic [63:0] s_t1, s_t2, s_t4, s_rs;
  int d0;

  initial begin
    reset = 1'b1; start = 1'b0; frame_len = '0;
    in_valid = 1'b0; in_sym = '0; out_ready = 1'b1;
    s_t1 = 64'({2'b11, 2'b10, 2'b00, 2'b10, 2'b11});
    s_t2 = 64'({2'b00, 2'b00, 2'b11});
    s_t4 = 64'({2'b11, 2'b01, {6{2'b10}}, 2'b01, 2'b11});
    s_rs = 64'({2'b11, 2'b10, 2'b10, 2'b01, 2'b11});
    repeat (3) @(negedge clk);
    check("rst_decreset", dec_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_odata", out_data, 0);
    check("rst_done", done, 0);
    check("rst_tailerr", tail_err, 0);

    // N=3: bits 1,0,1 -> 0x05, trellis closes.
    d0 = done_cnt;
    begin_frame("t1", 8'd3);
    feed(s_t1, 0, 5);
    end_frame("t1", d0, 1, 8'h05, 1'b0);

    // N=1 with an unterminated tail.
    d0 = done_cnt;
    begin_frame("t2", 8'd1);
    feed(s_t2, 0, 3);
    end_frame("t2", d0, 1, 8'h01, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_errheld", tail_err, 1);

    // N=16 zeros, sink back-pressure on the first word.
    d0 = done_cnt;
    out_ready = 1'b0;
    begin_frame("t3", 8'd16);
    feed(64'd0, 0, 8);
    @(negedge clk);
    check("t3_ovalid", out_valid, 1);
    check("t3_stall", in_ready, 0);
    repeat (3) @(negedge clk);
    check("t3_hold", out_data, 0);
    check("t3_stall2", in_ready, 0);
    check("t3_nolast", out_last, 0);
    out_ready = 1'b1;
    feed(64'd0, 0, 10);
    end_frame("t3", d0, 2, 8'h00, 1'b0);
    check("t3_w1", words.size() == 2 ? words[1] : 8'hEE, 8'h00);

    // N=8 all ones with a stray start mid-frame.
    d0 = done_cnt;
    begin_frame("t4", 8'd8);
    feed(s_t4, 0, 4);
    @(negedge clk);
    start = 1'b1; frame_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    feed(s_t4, 4, 6);
    end_frame("t4", d0, 1, 8'hFF, 1'b0);

    // Zero-length start is ignored.
    @(negedge clk);
    start = 1'b1; frame_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("z_busy", busy, 0);
      check("z_decreset", dec_reset, 0);
    end

    // Reset after 5 data symbols of a 10-bit frame.
    d0 = done_cnt;
    begin_frame("rs", 8'd10);
    feed(s_rs, 0, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rs_busy", busy, 0);
    check("rs_ready", in_ready, 0);
    check("rs_ovalid", out_valid, 0);
    check("rs_words", words.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rs_nodone", done_cnt - d0, 0);

    // Same N=3 frame again; a stale packer position would shift the bits.
    d0 = done_cnt;
    begin_frame("t5", 8'd3);
    feed(s_t1, 0, 5);
    end_frame("t5", d0, 1, 8'h05, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
